field_cfg_loader: RTL and testbench

- Sequencer that copies a stored field configuration into the live field state memory.
- Walks every cell address and drives the x/y address of the combinational config ROM.
- Writes each cell's state into the field memory write port through a valid/ready write handshake.
- Sits between the config ROM and the field memory, triggered by the top-level controller (power-up, or a user "reload" request).

---
 rtl/field_cfg_loader.sv | 157 +++++++++++++++
 tb/tb_field_cfg_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/field_cfg_loader.sv
// field_cfg_loader
//   Copies a stored field configuration from a combinational config ROM into
//   the live field state memory. The scan counter walks every cell in
//   row-major order (x fastest); each ROM bit is captured into a registered
//   write port that handshakes with the field memory via valid/ready.
//
// Parameters:
//   FIELD_W, FIELD_H      field size in cells (each >= 2)
//   X_ADR_SIZE/Y_ADR_SIZE derived address widths
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               load request, honoured only in IDLE
//   i_clear               (FIELD_CFG_LOADER_CLEAR_EN only) write zeros instead of ROM data
//   o_busy                high while scanning or draining
//   o_done                one-cycle pulse after the last write is accepted
//   o_rom_x/y_adr         config ROM address (the scan counter itself)
//   i_rom_cell_state      config ROM data for o_rom_*_adr
//   o_wr_en/o_wr_*_adr/o_wr_cell_state   registered write request
//   i_wr_ready            field memory accepts when o_wr_en && i_wr_ready
//
// Optional feature macro: FIELD_CFG_LOADER_CLEAR_EN
module field_cfg_loader #(
  parameter int FIELD_W = 64,
  parameter int FIELD_H = 48,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
`ifdef FIELD_CFG_LOADER_CLEAR_EN
  input  logic                  i_clear,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic [X_ADR_SIZE-1:0] o_rom_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_rom_y_adr,
  input  logic                  i_rom_cell_state,
  output logic                  o_wr_en,
  output logic [X_ADR_SIZE-1:0] o_wr_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_wr_y_adr,
  output logic                  o_wr_cell_state,
  input  logic                  i_wr_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  state_t                  state, state_nx;
  logic [X_ADR_SIZE-1:0]   x_q, x_nx;
  logic [Y_ADR_SIZE-1:0]   y_q, y_nx;
  logic                    clear_q, clear_nx;
  logic                    clear_req;
  logic                    busy_nx, done_nx;
  logic                    wr_en_nx, wr_d_nx;
  logic [X_ADR_SIZE-1:0]   wr_x_nx;
  logic [Y_ADR_SIZE-1:0]   wr_y_nx;
  logic                    room;

`ifdef FIELD_CFG_LOADER_CLEAR_EN
  assign clear_req = i_clear;
`else
  assign clear_req = 1'b0;
`endif

  assign o_rom_x_adr = x_q;
  assign o_rom_y_adr = y_q;

  always_comb begin
    state_nx = state;
    x_nx     = x_q;
    y_nx     = y_q;
    clear_nx = clear_q;
    wr_en_nx = o_wr_en;
    wr_x_nx  = o_wr_x_adr;
    wr_y_nx  = o_wr_y_adr;
    wr_d_nx  = o_wr_cell_state;
    // The write register can take a new cell if it is empty or its
    // current contents are being accepted this edge.
    room     = !o_wr_en || i_wr_ready;

    case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = SCAN;
          x_nx     = '0;
          y_nx     = '0;
          clear_nx = clear_req;
        end
      end
      SCAN: begin
        if (room) begin
          wr_en_nx = 1'b1;
          wr_x_nx  = x_q;
          wr_y_nx  = y_q;
          wr_d_nx  = clear_q ? 1'b0 : i_rom_cell_state;
          if (x_q == X_LAST) begin
            x_nx = '0;
            if (y_q == Y_LAST) begin
              y_nx     = '0;
              state_nx = DRAIN;
            end else begin
              y_nx = y_q + 1'b1;
            end
          end else begin
            x_nx = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (room) begin
          wr_en_nx = 1'b0;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_nx = (state_nx == SCAN) || (state_nx == DRAIN);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      x_q             <= '0;
      y_q             <= '0;
      clear_q         <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_wr_en         <= 1'b0;
      o_wr_x_adr      <= '0;
      o_wr_y_adr      <= '0;
      o_wr_cell_state <= 1'b0;
    end else begin
      state           <= state_nx;
      x_q             <= x_nx;
      y_q             <= y_nx;
      clear_q         <= clear_nx;
      o_busy          <= busy_nx;
      o_done          <= done_nx;
      o_wr_en         <= wr_en_nx;
      o_wr_x_adr      <= wr_x_nx;
      o_wr_y_adr      <= wr_y_nx;
      o_wr_cell_state <= wr_d_nx;
    end
  end

endmodule

// File: tb/tb_field_cfg_loader.sv
// Testbench for field_cfg_loader: a 4x3 instance (A) for timing, backpressure,
// ignored starts, reset abort and the optional clear load, plus a 5x3
// instance (B) for non-power-of-two wrap. Expected writes are queued by the
// stimulus and popped by per-instance monitors on accepted handshakes.
module tb_field_cfg_loader;
  localparam int AW = 4, AH = 3, AN = AW * AH;
  localparam int BW = 5, BH = 3, BN = BW * BH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, ready_a = 1'b1, clear = 1'b0;
  logic       busy_a, done_a, en_a, rom_a, wd_a;
  logic [1:0] rx_a, wx_a, ry_a, wy_a;

  logic       start_b = 1'b0, ready_b = 1'b1;
  logic       busy_b, done_b, en_b, rom_b, wd_b;
  logic [2:0] rx_b, wx_b;
  logic [1:0] ry_b, wy_b;

  int rom_mode = 0;
  assign rom_a = (rom_mode == 1) ? 1'b1 : ~rx_a[0];
  assign rom_b = rx_b[0] ^ ry_b[0];

  field_cfg_loader #(.FIELD_W(AW), .FIELD_H(AH)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
`ifdef FIELD_CFG_LOADER_CLEAR_EN
    .i_clear(clear),
`endif
    .o_busy(busy_a), .o_done(done_a),
    .o_rom_x_adr(rx_a), .o_rom_y_adr(ry_a), .i_rom_cell_state(rom_a),
    .o_wr_en(en_a), .o_wr_x_adr(wx_a), .o_wr_y_adr(wy_a),
    .o_wr_cell_state(wd_a), .i_wr_ready(ready_a)
  );

  field_cfg_loader #(.FIELD_W(BW), .FIELD_H(BH)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
`ifdef FIELD_CFG_LOADER_CLEAR_EN
    .i_clear(1'b0),
`endif
    .o_busy(busy_b), .o_done(done_b),
    .o_rom_x_adr(rx_b), .o_rom_y_adr(ry_b), .i_rom_cell_state(rom_b),
    .o_wr_en(en_b), .o_wr_x_adr(wx_b), .o_wr_y_adr(wy_b),
    .o_wr_cell_state(wd_b), .i_wr_ready(ready_b)
  );

  int errors = 0, checks = 0;
  int q_a[$], q_b[$];
  int acc_a = 0, acc_b = 0;
  bit stall_a = 0;
  int held_a = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pk(input int x, input int y, input int d);
    return x * 100 + y * 10 + d;
  endfunction

  function automatic int exp_a(input int x, input int y, input bit clr);
    if (clr) return 0;
    if (rom_mode == 1) return 1;
    return (((y * AW + x) % 2) == 0) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: pops on accepted writes, checks held data during stalls.
  always @(negedge clk) begin
    if (rst) begin
      stall_a = 0;
    end else begin
      if (stall_a)
        chk("a_hold", pk(wx_a, wy_a, wd_a) + (en_a ? 1000 : 0), held_a + 1000);
      if (en_a && ready_a) begin
        if (q_a.size() == 0) chk("a_extra_write", pk(wx_a, wy_a, wd_a), -1);
        else chk("a_write", pk(wx_a, wy_a, wd_a), q_a.pop_front());
        acc_a++;
        stall_a = 0;
      end else if (en_a) begin
        stall_a = 1;
        held_a  = pk(wx_a, wy_a, wd_a);
      end else begin
        stall_a = 0;
      end
    end
  end

  // Monitor B: pops on accepted writes, x must stay within 0..4.
  always @(negedge clk) begin
    if (!rst && en_b && ready_b) begin
      chk("b_x_range", (wx_b < 3'd5) ? 1 : 0, 1);
      if (q_b.size() == 0) chk("b_extra_write", pk(wx_b, wy_b, wd_b), -1);
      else chk("b_write", pk(wx_b, wy_b, wd_b), q_b.pop_front());
      acc_b++;
    end
  end

  // One load on A with a cycle-by-cycle timeline check. stall_len cycles of
  // ready=0 are applied while the 6th write is presented (cycle k=7).
  task automatic run_a(input int stall_len, input bit extra, input bit clr);
    int last_en;
    acc_a = 0;
    for (int y = 0; y < AH; y++)
      for (int x = 0; x < AW; x++)
        q_a.push_back(pk(x, y, exp_a(x, y, clr)));
    last_en = AN + 1 + stall_len;
    start_a = 1'b1;
    clear   = clr;
    step();
    start_a = 1'b0;
    clear   = 1'b0;
    for (int k = 1; k <= last_en + 3; k++) begin
      chk($sformatf("a_wr_en_k%0d", k), en_a, (k >= 2 && k <= last_en) ? 1 : 0);
      chk($sformatf("a_busy_k%0d", k), busy_a, (k <= last_en) ? 1 : 0);
      chk($sformatf("a_done_k%0d", k), done_a, (k == last_en + 1) ? 1 : 0);
      ready_a = (stall_len > 0 && k >= 7 && k < 7 + stall_len) ? 1'b0 : 1'b1;
      start_a = (extra && (k == 5 || k == last_en + 1)) ? 1'b1 : 1'b0;
      step();
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    chk("a_accepted", acc_a, AN);
    chk("a_queue_left", q_a.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    step();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_wr_en", en_a, 0);
    chk("rst_wr_adr_data", pk(wx_a, wy_a, wd_a), 0);
    chk("rst_rom_adr", pk(rx_a, ry_a, 0), 0);
    chk("rst_b_busy", busy_b, 0);
    rst = 1'b0;
    step();

    run_a(0, 0, 0);   // plain load
    run_a(3, 0, 0);   // backpressure on (1,1)
    run_a(0, 1, 0);   // starts during SCAN and DONE ignored

    // Non-power-of-two width on B.
    acc_b = 0;
    for (int y = 0; y < BH; y++)
      for (int x = 0; x < BW; x++)
        q_b.push_back(pk(x, y, (x % 2) ^ (y % 2)));
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 60 && !done_b; k++) step();
    chk("b_done_seen", done_b, 1);
    step();
    chk("b_accepted", acc_b, BN);
    chk("b_queue_left", q_b.size(), 0);

    // Reset after the 7th accepted write, then a clean reload.
    acc_a = 0;
    for (int y = 0; y < AH; y++)
      for (int x = 0; x < AW; x++)
        q_a.push_back(pk(x, y, exp_a(x, y, 0)));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (8) step();
    chk("a_acc_before_rst", acc_a, 7);
    chk("a_en_before_rst", en_a, 1);
    rst = 1'b1;
    #1;
    chk("a_rst_wr_en", en_a, 0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_done", done_a, 0);
    chk("a_rst_rom_adr", pk(rx_a, ry_a, 0), 0);
    q_a.delete();
    step();
    rst = 1'b0;
    step();
    run_a(0, 0, 0);

`ifdef FIELD_CFG_LOADER_CLEAR_EN
    rom_mode = 1;
    run_a(0, 0, 1);   // clear load: all zeros
    run_a(0, 0, 0);   // ROM load: all ones
    rom_mode = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
